// File: rtl/pixel_frame_ctrl_if.sv
// Sensor-array control lines plus the row valid/ready handshake of pixel_frame_ctrl.
interface pixel_frame_ctrl_if #(
  parameter int PIXEL_BITS         = 8,
  parameter int PIXEL_ARRAY_HEIGHT = 2
);
  localparam int ROW_W = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1;

  logic                          START;
  logic                          ERASE;
  logic                          EXPOSE;
  logic                          ANALOG_RAMP;
  logic [PIXEL_BITS-1:0]         DIGITAL_RAMP;
  logic [PIXEL_ARRAY_HEIGHT-1:0] READ;
  logic [ROW_W-1:0]              ROW_INDEX;
  logic                          ROW_VALID;
  logic                          ROW_READY;
  logic                          BUSY;
  logic                          FRAME_DONE;

  modport master (
    input  START, ROW_READY,
    output ERASE, EXPOSE, ANALOG_RAMP, DIGITAL_RAMP, READ,
           ROW_INDEX, ROW_VALID, BUSY, FRAME_DONE
  );

  modport slave (
    output START, ROW_READY,
    input  ERASE, EXPOSE, ANALOG_RAMP, DIGITAL_RAMP, READ,
           ROW_INDEX, ROW_VALID, BUSY, FRAME_DONE
  );
endinterface

// File: rtl/pixel_frame_ctrl.sv
// Frame sequencer: erase, expose, ramp conversion and handshaked row readout.
// Define PIXEL_FRAME_CTRL_CONTINUOUS_EN for back-to-back frames after the first START.
//
// state      | meaning
// IDLE       | waiting for START
// ERASE      | one launch cycle, then ERASE high for ERASE_CYCLES
// EXPOSE     | EXPOSE high for EXPOSE_CYCLES
// CONVERT    | ANALOG_RAMP high, DIGITAL_RAMP counts 0 .. 2^PIXEL_BITS-1
// READOUT    | rows offered one at a time until each is accepted
module pixel_frame_ctrl #(
  parameter int PIXEL_BITS         = 8,
  parameter int PIXEL_ARRAY_HEIGHT = 2,
  parameter int ERASE_CYCLES       = 5,
  parameter int EXPOSE_CYCLES      = 255
) (
  input  logic                CLK,
  input  logic                RESET_N,
  pixel_frame_ctrl_if.master  bus
);

  localparam int              ROW_W        = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1;
  localparam logic [15:0]     ERASE_LOAD   = 16'(ERASE_CYCLES);
  localparam logic [15:0]     EXPOSE_LOAD  = 16'(EXPOSE_CYCLES - 1);
  localparam logic [15:0]     CONVERT_LOAD = 16'((1 << PIXEL_BITS) - 1);
  localparam logic [ROW_W-1:0] LAST_ROW    = ROW_W'(PIXEL_ARRAY_HEIGHT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ERASE,
    ST_EXPOSE,
    ST_CONVERT,
    ST_READOUT
  } state_t;

  state_t                        state_q, state_d;
  logic [15:0]                   cnt_q, cnt_d;
  logic [ROW_W-1:0]              row_q, row_d;
  logic                          erase_q, erase_d;
  logic                          expose_q, expose_d;
  logic                          analog_q, analog_d;
  logic [PIXEL_BITS-1:0]         digital_q, digital_d;
  logic [PIXEL_ARRAY_HEIGHT-1:0] read_q, read_d;
  logic                          valid_q, valid_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic                          go;
  logic                          launch;
`ifdef PIXEL_FRAME_CTRL_CONTINUOUS_EN
  logic                          run_q, run_d;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      row_q     <= '0;
      erase_q   <= 1'b0;
      expose_q  <= 1'b0;
      analog_q  <= 1'b0;
      digital_q <= '0;
      read_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef PIXEL_FRAME_CTRL_CONTINUOUS_EN
      run_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      row_q     <= row_d;
      erase_q   <= erase_d;
      expose_q  <= expose_d;
      analog_q  <= analog_d;
      digital_q <= digital_d;
      read_q    <= read_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef PIXEL_FRAME_CTRL_CONTINUOUS_EN
      run_q     <= run_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
`ifdef PIXEL_FRAME_CTRL_CONTINUOUS_EN
    // Once started, the IDLE cycle after FRAME_DONE restarts the frame by itself.
    go    = bus.START || run_q;
    run_d = run_q || ((state_q == ST_IDLE) && bus.START);
`else
    go    = bus.START;
`endif
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          state_d = ST_ERASE;
          cnt_d   = ERASE_LOAD;
        end
      end
      ST_ERASE: begin
        if (cnt_q == '0) begin
          state_d = ST_EXPOSE;
          cnt_d   = EXPOSE_LOAD;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_EXPOSE: begin
        if (cnt_q == '0) begin
          state_d = ST_CONVERT;
          cnt_d   = CONVERT_LOAD;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_CONVERT: begin
        if (cnt_q == '0) begin
          state_d = ST_READOUT;
          row_d   = '0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_READOUT: begin
        if (bus.ROW_READY) begin
          if (row_q == LAST_ROW) begin
            state_d = ST_IDLE;
            row_d   = '0;
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        row_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so every line changes on the transition edge.
  always_comb begin
    launch    = (state_d == ST_ERASE) && (cnt_d == ERASE_LOAD);
    erase_d   = (state_d == ST_ERASE) && !launch;
    expose_d  = (state_d == ST_EXPOSE);
    analog_d  = (state_d == ST_CONVERT);
    digital_d = analog_d ? ~cnt_d[PIXEL_BITS-1:0] : '0;
    valid_d   = (state_d == ST_READOUT);
    read_d    = '0;
    for (int i = 0; i < PIXEL_ARRAY_HEIGHT; i++) begin
      read_d[i] = valid_d && (row_d == ROW_W'(i));
    end
    done_d    = (state_q == ST_READOUT) && (state_d != ST_READOUT);
`ifdef PIXEL_FRAME_CTRL_CONTINUOUS_EN
    busy_d    = ((state_d != ST_IDLE) && !launch) || run_q;
`else
    busy_d    = (state_d != ST_IDLE) && !launch;
`endif
  end

  assign bus.ERASE        = erase_q;
  assign bus.EXPOSE       = expose_q;
  assign bus.ANALOG_RAMP  = analog_q;
  assign bus.DIGITAL_RAMP = digital_q;
  assign bus.READ         = read_q;
  assign bus.ROW_INDEX    = row_q;
  assign bus.ROW_VALID    = valid_q;
  assign bus.BUSY         = busy_q;
  assign bus.FRAME_DONE   = done_q;

endmodule

// File: tb/tb_pixel_frame_ctrl.sv
// Directed bench for pixel_frame_ctrl (PIXEL_BITS=4, 2 rows, ERASE 3, EXPOSE 10).
module tb_pixel_frame_ctrl;
  localparam int PB = 4;
  localparam int PH = 2;
  localparam int EC = 3;
  localparam int XC = 10;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;

  pixel_frame_ctrl_if #(.PIXEL_BITS(PB), .PIXEL_ARRAY_HEIGHT(PH)) bus ();

  pixel_frame_ctrl #(
    .PIXEL_BITS(PB), .PIXEL_ARRAY_HEIGHT(PH), .ERASE_CYCLES(EC), .EXPOSE_CYCLES(XC)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .bus(bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          edge_n;
    logic [12:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   viol     = 0;
  int   done_cnt = 0;

  // {ERASE, EXPOSE, ANALOG_RAMP, DIGITAL_RAMP, READ, ROW_VALID, ROW_INDEX, BUSY, FRAME_DONE}
  function automatic logic [12:0] pk(logic er, logic ex, logic an, logic [3:0] dg,
                                     logic [1:0] rd, logic vl, logic ix, logic bs, logic dn);
    return {er, ex, an, dg, rd, vl, ix, bs, dn};
  endfunction

  function automatic logic [12:0] obs();
    return {bus.ERASE, bus.EXPOSE, bus.ANALOG_RAMP, bus.DIGITAL_RAMP, bus.READ,
            bus.ROW_VALID, bus.ROW_INDEX, bus.BUSY, bus.FRAME_DONE};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    if (bus.ERASE && bus.EXPOSE) viol++;
    if (!$onehot0(bus.READ)) viol++;
    if (!bus.ANALOG_RAMP && (bus.DIGITAL_RAMP != '0)) viol++;
    if (bus.FRAME_DONE) done_cnt++;
  endtask

  // One frame with ROW_READY high; optional START pulses seen at edges 6, 31, 32 and 33.
  task automatic run_table(input bit pulses);
    bus.ROW_READY = 1'b1;
    bus.START     = 1'b1;
    for (int e = 0; e <= 33; e++) begin
      tick();
      bus.START = pulses && (e == 5 || e == 30 || e == 31 || e == 32);
      foreach (vecs[j]) begin
        if (vecs[j].edge_n == e) chk($sformatf("frame_e%0d", e), int'(obs()), int'(vecs[j].exp));
      end
    end
  endtask

  initial begin
    bus.START     = 1'b0;
    bus.ROW_READY = 1'b0;
    vecs.push_back('{0,  pk(0, 0, 0, 4'd0,  2'b00, 0, 0, 0, 0)});
    vecs.push_back('{1,  pk(1, 0, 0, 4'd0,  2'b00, 0, 0, 1, 0)});
    vecs.push_back('{3,  pk(1, 0, 0, 4'd0,  2'b00, 0, 0, 1, 0)});
    vecs.push_back('{4,  pk(0, 1, 0, 4'd0,  2'b00, 0, 0, 1, 0)});
    vecs.push_back('{13, pk(0, 1, 0, 4'd0,  2'b00, 0, 0, 1, 0)});
    vecs.push_back('{14, pk(0, 0, 1, 4'd0,  2'b00, 0, 0, 1, 0)});
    vecs.push_back('{21, pk(0, 0, 1, 4'd7,  2'b00, 0, 0, 1, 0)});
    vecs.push_back('{29, pk(0, 0, 1, 4'd15, 2'b00, 0, 0, 1, 0)});
    vecs.push_back('{30, pk(0, 0, 0, 4'd0,  2'b01, 1, 0, 1, 0)});
    vecs.push_back('{31, pk(0, 0, 0, 4'd0,  2'b10, 1, 1, 1, 0)});
    vecs.push_back('{32, pk(0, 0, 0, 4'd0,  2'b00, 0, 0, 0, 1)});
    vecs.push_back('{33, pk(0, 0, 0, 4'd0,  2'b00, 0, 0, 0, 0)});

    repeat (2) @(posedge CLK);
    #1;
    chk("reset_outputs", int'(obs()), 0);
    @(negedge CLK) RESET_N = 1'b1;
    tick();
    chk("idle_after_reset", int'(obs()), 0);

`ifdef PIXEL_FRAME_CTRL_CONTINUOUS_EN
    begin
      int busy_low = 0;
      done_cnt = 0;
      bus.ROW_READY = 1'b1;
      bus.START = 1'b1;
      tick();
      bus.START = 1'b0;
      chk("cont_edge0", int'(obs()), 0);
      for (int e = 1; e <= 100; e++) begin
        tick();
        if (!bus.BUSY) busy_low++;
        if (e == 32 || e == 65 || e == 98) chk($sformatf("cont_done_e%0d", e), int'(bus.FRAME_DONE), 1);
        if (e == 33) chk("cont_launch_e33", int'(bus.ERASE), 0);
        if (e == 34) chk("cont_erase_e34", int'(bus.ERASE), 1);
        if (e == 54) chk("cont_ramp_e54", int'(bus.DIGITAL_RAMP), 7);
        if (e == 67) chk("cont_erase_e67", int'(bus.ERASE), 1);
      end
      chk("cont_done_count", done_cnt, 3);
      chk("cont_busy_low", busy_low, 0);
    end
`else
    done_cnt = 0;
    run_table(1'b0);
    chk("single_done_count", done_cnt, 1);

    done_cnt = 0;
    run_table(1'b1);
    tick();
    chk("restart_erase", int'(obs()), int'(pk(1, 0, 0, 4'd0, 2'b00, 0, 0, 1, 0)));
    repeat (30) tick();
    tick();
    chk("restart_done", int'(obs()), int'(pk(0, 0, 0, 4'd0, 2'b00, 0, 0, 0, 1)));
    chk("ignored_start_done_count", done_cnt, 2);
    tick();

    bus.ROW_READY = 1'b0;
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    repeat (29) tick();
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("bp_row0_hold%0d", k), int'(obs()), int'(pk(0, 0, 0, 4'd0, 2'b01, 1, 0, 1, 0)));
    end
    bus.ROW_READY = 1'b1;
    tick();
    chk("bp_row1", int'(obs()), int'(pk(0, 0, 0, 4'd0, 2'b10, 1, 1, 1, 0)));
    bus.ROW_READY = 1'b0;
    tick();
    chk("bp_row1_hold", int'(obs()), int'(pk(0, 0, 0, 4'd0, 2'b10, 1, 1, 1, 0)));
    bus.ROW_READY = 1'b1;
    tick();
    chk("bp_done", int'(obs()), int'(pk(0, 0, 0, 4'd0, 2'b00, 0, 0, 0, 1)));
    tick();
    chk("bp_idle", int'(obs()), 0);

    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    repeat (21) tick();
    chk("pre_reset_ramp", int'(obs()), int'(pk(0, 0, 1, 4'd7, 2'b00, 0, 0, 1, 0)));
    #2 RESET_N = 1'b0;
    #1 chk("async_reset", int'(obs()), 0);
    @(negedge CLK) RESET_N = 1'b1;
    repeat (3) tick();
    chk("no_resume", int'(obs()), 0);
    done_cnt = 0;
    run_table(1'b0);
    chk("post_reset_done_count", done_cnt, 1);
`endif

    chk("exclusivity", viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
